conv_accbin_seq: RTL

- Time-multiplexed, parametrised accumulate-and-binarise stage for the binary conv layers.
- Replaces one spatially unrolled accumulator per output channel with a single PIX-lane datapath.
- Accepts a stream of per-pixel partial maps: N_IN beats per output channel, N_CH channels per frame.
- Sums the N_IN beats per pixel, compares each sum against that channel's programmable offset, and emits one PIX-bit binary map per channel over a valid/ready handshake.

---
 rtl/conv_accbin_seq_if.sv | 46 ++++
 rtl/conv_accbin_seq.sv | 110 +++++++++++
 2 files changed

// File: rtl/conv_accbin_seq_if.sv
// Bus bundle for conv_accbin_seq: beat input, map output and offset write port.
// CONVACC_POPCNT_EN adds o_ones (number of 1s in o_data).
interface conv_accbin_seq_if #(
  parameter int N_CH = 60,
  parameter int N_IN = 18,
  parameter int PIX  = 64,
  parameter int bW   = 8
);
  localparam int AW = bW + $clog2(N_IN);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic              i_clear;
  logic              i_valid;
  logic              o_ready;
  logic [PIX*bW-1:0] i_data;
  logic              o_valid;
  logic              i_ready;
  logic [PIX-1:0]    o_data;
  logic [CW-1:0]     o_ch;
  logic              o_frame_last;
  logic              i_off_we;
  logic [CW-1:0]     i_off_addr;
  logic [AW-1:0]     i_off_data;
`ifdef CONVACC_POPCNT_EN
  localparam int OW = $clog2(PIX + 1);
  logic [OW-1:0]     o_ones;

  modport slave (
    input  i_clear, i_valid, i_data, i_ready, i_off_we, i_off_addr, i_off_data,
    output o_ready, o_valid, o_data, o_ch, o_frame_last, o_ones
  );
  modport master (
    output i_clear, i_valid, i_data, i_ready, i_off_we, i_off_addr, i_off_data,
    input  o_ready, o_valid, o_data, o_ch, o_frame_last, o_ones
  );
`else
  modport slave (
    input  i_clear, i_valid, i_data, i_ready, i_off_we, i_off_addr, i_off_data,
    output o_ready, o_valid, o_data, o_ch, o_frame_last
  );
  modport master (
    output i_clear, i_valid, i_data, i_ready, i_off_we, i_off_addr, i_off_data,
    input  o_ready, o_valid, o_data, o_ch, o_frame_last
  );
`endif
endinterface

// File: rtl/conv_accbin_seq.sv
// Time-multiplexed accumulate-and-binarise stage: sums N_IN beats per pixel
// lane, compares against the channel's offset and emits one PIX-bit map per
// channel through a one-entry output register.
// Optional macro CONVACC_POPCNT_EN: registered popcount of o_data on o_ones.
module conv_accbin_seq #(
  parameter int N_CH = 60,
  parameter int N_IN = 18,
  parameter int PIX  = 64,
  parameter int bW   = 8
) (
  input  logic           clk,
  input  logic           rst,
  conv_accbin_seq_if.slave bus
);
  localparam int AW  = bW + $clog2(N_IN);
  localparam int CW  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BCW = (N_IN > 1) ? $clog2(N_IN) : 1;
`ifdef CONVACC_POPCNT_EN
  localparam int OW  = $clog2(PIX + 1);
  logic [OW-1:0] ones_next;
`endif

  logic [BCW-1:0] beat_cnt;
  logic [CW-1:0]  ch_cnt;
  logic [AW-1:0]  acc [PIX];
  logic [AW-1:0]  off [N_CH];
  logic [AW-1:0]  sum [PIX];
  logic [AW-1:0]  cur_off;
  logic [PIX-1:0] bin;
  logic           accept;
  logic           last_beat;
  logic           off_hit;

  assign bus.o_ready = !bus.o_valid || bus.i_ready;

  // Beat acceptance (clear wins), per-lane sums and threshold compare
  always_comb begin
    accept    = bus.i_valid && bus.o_ready && !bus.i_clear;
    last_beat = (beat_cnt == BCW'(N_IN - 1));
    off_hit   = ({1'b0, bus.i_off_addr} < (CW + 1)'(N_CH));
    cur_off   = off[ch_cnt];
    bin       = '0;
    for (int unsigned p = 0; p < PIX; p++) begin
      sum[p] = acc[p] + AW'(bus.i_data[p*bW +: bW]);
      bin[p] = (sum[p] >= cur_off);
    end
`ifdef CONVACC_POPCNT_EN
    ones_next = '0;
    for (int unsigned p = 0; p < PIX; p++) begin
      ones_next = ones_next + OW'(bin[p]);
    end
`endif
  end

  // Beat/channel counters and lane accumulators
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      ch_cnt   <= '0;
      for (int unsigned p = 0; p < PIX; p++) acc[p] <= '0;
    end else if (bus.i_clear) begin
      beat_cnt <= '0;
      ch_cnt   <= '0;
      for (int unsigned p = 0; p < PIX; p++) acc[p] <= '0;
    end else if (accept) begin
      if (last_beat) begin
        beat_cnt <= '0;
        ch_cnt   <= (ch_cnt == CW'(N_CH - 1)) ? '0 : ch_cnt + 1'b1;
        for (int unsigned p = 0; p < PIX; p++) acc[p] <= '0;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
        for (int unsigned p = 0; p < PIX; p++) acc[p] <= sum[p];
      end
    end
  end

  // One-entry output register; a new map may load in the cycle the old one drains
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.o_valid      <= 1'b0;
      bus.o_data       <= '0;
      bus.o_ch         <= '0;
      bus.o_frame_last <= 1'b0;
`ifdef CONVACC_POPCNT_EN
      bus.o_ones       <= '0;
`endif
    end else if (bus.i_clear) begin
      bus.o_valid      <= 1'b0;
    end else if (accept && last_beat) begin
      bus.o_valid      <= 1'b1;
      bus.o_data       <= bin;
      bus.o_ch         <= ch_cnt;
      bus.o_frame_last <= (ch_cnt == CW'(N_CH - 1));
`ifdef CONVACC_POPCNT_EN
      bus.o_ones       <= ones_next;
`endif
    end else if (bus.i_ready) begin
      bus.o_valid      <= 1'b0;
    end
  end

  // Offset register file; a same-cycle write is seen only by later compares
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < N_CH; c++) off[c] <= '0;
    end else if (bus.i_off_we && off_hit) begin
      off[bus.i_off_addr] <= bus.i_off_data;
    end
  end
endmodule
